fpu_status_ctrl: RTL

- Consumer end of the rounder's exception-flag interface.
- Receives the per-operation 5-bit IEEE flag vector {INV, DBZ, OVF, UNF, INX} from the rounder and accumulates it into sticky status flags.
- Holds the trap-enable and rounding-mode control register, and feeds OVFen/UNFen back to the rounder.
- Raises a trap request when an enabled exception occurs, with a handshake to the trap handler.

---
 rtl/fpu_status_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fpu_status_ctrl.sv
// FP exception status/control: sticky IEEE flags, trap enables + rounding mode, trap handshake.
// Latency: flags, CAUSE and trap_req update one cycle after the accepting edge; CSR reads are combinational.
// Backpressure: ieee_ready drops while a trap is pending. Optional trap counter under FPU_STATUS_TRAPCNT_EN.
module fpu_status_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter logic [1:0]  RM_RST = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ieee_valid,
    input  logic [4:0] IEEEp,
    output logic       ieee_ready,
    input  logic       csr_wr,
    input  logic [1:0] csr_addr,
    input  logic [7:0] csr_wdata,
    output logic [7:0] csr_rdata,
    output logic       OVFen,
    output logic       UNFen,
    output logic [1:0] rm,
    output logic       trap_req,
    input  logic       trap_ack,
    output logic [4:0] trap_cause
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_TRAP = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_flags;
    logic [6:0] r_ctrl;
    logic [4:0] r_cause;

    logic       w_accept;
    logic [4:0] w_hit;
    logic       w_trap_entry;
    logic       w_wr_flags;
    logic       w_wr_ctrl;
    logic       w_wr_cause;
    logic [4:0] w_flags_nxt;
    logic       w_unused;

    assign w_wr_flags = csr_wr && (csr_addr == 2'd0);
    assign w_wr_ctrl  = csr_wr && (csr_addr == 2'd1);
    assign w_wr_cause = csr_wr && (csr_addr == 2'd2);

    assign w_accept = ieee_valid && (r_state == S_IDLE);
    // Trap decision deliberately uses the pre-edge enables; a same-cycle CTRL write applies next op.
    assign w_hit    = IEEEp & r_ctrl[4:0];

    // Software write and hardware flags merge so no raised flag is ever dropped.
    assign w_flags_nxt = (w_wr_flags ? csr_wdata[4:0] : r_flags) | (w_accept ? IEEEp : 5'b0);

    always_comb begin
        w_state_nxt  = r_state;
        w_trap_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_hit != 5'b0)) begin
                    w_state_nxt  = S_TRAP;
                    w_trap_entry = 1'b1;
                end
            end
            S_TRAP: begin
                if (trap_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_flags <= 5'b0;
            r_ctrl  <= {RM_RST, 5'b0};
            r_cause <= 5'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flags <= w_flags_nxt;
            if (w_wr_ctrl) begin
                r_ctrl <= csr_wdata[6:0];
            end
            if (w_trap_entry) begin
                r_cause <= w_hit;
            end else if (w_wr_cause) begin
                r_cause <= csr_wdata[4:0];
            end
        end
    end

`ifdef FPU_STATUS_TRAPCNT_EN
    logic [CNT_W-1:0] r_trapcnt;

    // A clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_trapcnt <= '0;
        end else if (csr_wr && (csr_addr == 2'd3)) begin
            r_trapcnt <= '0;
        end else if (w_trap_entry && (r_trapcnt != {CNT_W{1'b1}})) begin
            r_trapcnt <= r_trapcnt + 1'b1;
        end
    end

    assign w_unused = csr_wdata[7];
`else
    assign w_unused = csr_wdata[7] ^ (CNT_W == 0);
`endif

    always_comb begin
        csr_rdata = 8'h00;
        case (csr_addr)
            2'd0:    csr_rdata = {3'b000, r_flags};
            2'd1:    csr_rdata = {1'b0, r_ctrl};
            2'd2:    csr_rdata = {3'b000, r_cause};
`ifdef FPU_STATUS_TRAPCNT_EN
            2'd3:    csr_rdata = 8'(r_trapcnt);
`endif
            default: csr_rdata = 8'h00;
        endcase
    end

    assign ieee_ready = (r_state == S_IDLE);
    assign trap_req   = (r_state == S_TRAP);
    assign trap_cause = r_cause;
    assign OVFen      = r_ctrl[2];
    assign UNFen      = r_ctrl[1];
    assign rm         = r_ctrl[6:5];

endmodule
